hc_csr_regfile: RTL

Parametrised CCI-P MMIO control/status register file for HardCloud AFUs.
- Decodes MMIO writes for the DSM base, the control register and a table of `NUM_BUFFERS` address/size buffer descriptors.
- Serves MMIO reads with a fixed-latency pipelined response.
- Runs the kernel control state machine: soft reset, start, stop, done.
- Sits between the CCI-P shim and the kernel's read/write engines. It replaces per-sample write-only decode functions.

---
 rtl/hc_csr_regfile.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hc_csr_regfile.sv
// CCI-P MMIO control/status register file for HardCloud AFUs.
// Decodes MMIO writes for the DSM base, CONTROL and a table of buffer
// descriptors, returns MMIO reads two cycles after the request, and runs
// the kernel control state machine (soft reset, start, stop, done).

package hc_ccip_pkg;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef struct packed {
    t_ccip_mmioAddr address;  // 4-byte units
    logic [1:0]     length;   // 2'd1 = 8 bytes, otherwise 4 bytes
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_clData        data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

module hc_csr_regfile
  import hc_ccip_pkg::*;
#(
  parameter int          NUM_BUFFERS = 3,
  parameter logic [15:0] BUF_BASE    = 16'h120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  t_if_ccip_c0_Rx           cp2af_mmio_c0rx,
  output t_if_ccip_c2_Tx           af2cp_mmio_c2tx,
  input  logic                     kernel_done,
  output logic [63:0]              dsm_base,
  output logic [NUM_BUFFERS*64-1:0] buf_addr,
  output logic [NUM_BUFFERS*32-1:0] buf_size,
  output logic [NUM_BUFFERS-1:0]   buf_valid,
  output logic                     kernel_reset,
  output logic                     kernel_start,
  output logic                     kernel_running
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;

  localparam logic [17:0] ADDR_STATUS = 18'h100;
  localparam logic [17:0] ADDR_DSM    = 18'h110;
  localparam logic [17:0] ADDR_CTRL   = 18'h118;
  localparam logic [15:0] WINDOW_END  = 16'h100;

  // Byte address of descriptor idx (address word, or size word when is_size).
  function automatic logic [17:0] desc_byte(input int idx, input logic is_size);
    desc_byte = {2'b00, BUF_BASE} + (18'(idx) << 4) + (is_size ? 18'd8 : 18'd0);
  endfunction

  // 64-bit register update: 8B writes replace all, 4B writes keep the upper half.
  function automatic logic [63:0] merge_wr(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic        full);
    merge_wr = full ? new_v : {old_v[63:32], new_v[31:0]};
  endfunction

  // Request decode; read and write share one header.
  logic [17:0] byte_addr_s;
  logic        in_window_s;
  logic        wr_hit_s;
  logic        rd_hit_s;
  logic        wr_full_s;
  logic [63:0] wr_data_s;
  logic        ctrl_wr_s;
  logic [31:0] ctrl_val_s;
  logic        dsm_wr_s;
  logic        unused_ok_s;

  assign byte_addr_s = {cp2af_mmio_c0rx.hdr.address, 2'b00};
  assign in_window_s = (cp2af_mmio_c0rx.hdr.address < WINDOW_END);
  assign wr_hit_s    = cp2af_mmio_c0rx.mmioWrValid & in_window_s;
  assign rd_hit_s    = cp2af_mmio_c0rx.mmioRdValid & in_window_s;
  assign wr_full_s   = (cp2af_mmio_c0rx.hdr.length == 2'd1);
  assign wr_data_s   = cp2af_mmio_c0rx.data[63:0];
  assign ctrl_wr_s   = wr_hit_s & (byte_addr_s == ADDR_CTRL);
  assign ctrl_val_s  = wr_data_s[31:0];
  assign dsm_wr_s    = wr_hit_s & (byte_addr_s == ADDR_DSM);
  assign unused_ok_s = ^{cp2af_mmio_c0rx.data[511:64], cp2af_mmio_c0rx.hdr.rsvd};

  // Register state.
  logic [63:0]            dsm_base_r;
  logic [31:0]            ctrl_r;
  logic [63:0]            buf_addr_r [NUM_BUFFERS];
  logic [31:0]            buf_size_r [NUM_BUFFERS];
  logic [NUM_BUFFERS-1:0] addr_wr_r;
  logic [NUM_BUFFERS-1:0] size_wr_r;
  logic [NUM_BUFFERS-1:0] buf_valid_r;
  logic [2:0]             state_r;
  logic                   done_r;
  logic                   start_r;
  logic                   kreset_r;
  logic                   running_r;

  // FSM next-state signals.
  logic [2:0] state_nxt_s;
  logic       done_nxt_s;
  logic       start_s;
  logic       clear_desc_s;

  logic [NUM_BUFFERS-1:0] wr_addr_hit_s;
  logic [NUM_BUFFERS-1:0] wr_size_hit_s;

  // Read path.
  logic [63:0]    rd_desc_s;
  logic [63:0]    rd_data_s;
  logic           rd_vld1_r;
  t_ccip_tid      rd_tid1_r;
  logic [63:0]    rd_data1_r;
  t_if_ccip_c2_Tx rsp_r;

  // Match a write against each descriptor's address and size words.
  always_comb begin
    wr_addr_hit_s = {NUM_BUFFERS{1'b0}};
    wr_size_hit_s = {NUM_BUFFERS{1'b0}};
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      wr_addr_hit_s[i] = wr_hit_s & (byte_addr_s == desc_byte(i, 1'b0));
      wr_size_hit_s[i] = wr_hit_s & (byte_addr_s == desc_byte(i, 1'b1));
    end
  end

  // Kernel control FSM; CONTROL=0 overrides everything including kernel_done.
  always_comb begin
    state_nxt_s  = state_r;
    done_nxt_s   = done_r;
    start_s      = 1'b0;
    clear_desc_s = 1'b0;
    if (ctrl_wr_s && (ctrl_val_s == 32'h0)) begin
      state_nxt_s  = S_RESET;
      done_nxt_s   = 1'b0;
      clear_desc_s = 1'b1;
    end else begin
      case (state_r)
        S_RESET: begin
          if (ctrl_wr_s && (ctrl_val_s == 32'h1)) state_nxt_s = S_IDLE;
          else                                    state_nxt_s = state_r;
        end
        S_IDLE, S_STOP: begin
          if (ctrl_wr_s && (ctrl_val_s == 32'h3)) begin
            state_nxt_s = S_RUN;
            start_s     = 1'b1;
            done_nxt_s  = 1'b0;
          end else if (ctrl_wr_s && (ctrl_val_s == 32'h1)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        S_RUN: begin
          if (ctrl_wr_s && (ctrl_val_s == 32'h7))      state_nxt_s = S_STOP;
          else if (ctrl_wr_s && (ctrl_val_s == 32'h1)) state_nxt_s = S_IDLE;
          else if (kernel_done)                        state_nxt_s = S_STOP;
          else                                         state_nxt_s = state_r;
          if (kernel_done) done_nxt_s = 1'b1;
          else             done_nxt_s = done_r;
        end
        default: begin
          state_nxt_s = S_RESET;
        end
      endcase
    end
  end

  // Registers, descriptor table and FSM state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      dsm_base_r  <= 64'h0;
      ctrl_r      <= 32'h0;
      addr_wr_r   <= {NUM_BUFFERS{1'b0}};
      size_wr_r   <= {NUM_BUFFERS{1'b0}};
      buf_valid_r <= {NUM_BUFFERS{1'b0}};
      state_r     <= S_RESET;
      done_r      <= 1'b0;
      start_r     <= 1'b0;
      kreset_r    <= 1'b1;
      running_r   <= 1'b0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr_r[i] <= 64'h0;
        buf_size_r[i] <= 32'h0;
      end
    end else begin
      if (dsm_wr_s) dsm_base_r <= merge_wr(dsm_base_r, wr_data_s, wr_full_s);
      if (ctrl_wr_s) ctrl_r <= ctrl_val_s;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (clear_desc_s) begin
          buf_addr_r[i]  <= 64'h0;
          buf_size_r[i]  <= 32'h0;
          addr_wr_r[i]   <= 1'b0;
          size_wr_r[i]   <= 1'b0;
          buf_valid_r[i] <= 1'b0;
        end else begin
          if (wr_addr_hit_s[i]) begin
            buf_addr_r[i] <= merge_wr(buf_addr_r[i], wr_data_s, wr_full_s);
            addr_wr_r[i]  <= 1'b1;
          end
          if (wr_size_hit_s[i]) begin
            buf_size_r[i] <= wr_data_s[31:0];
            size_wr_r[i]  <= 1'b1;
          end
          buf_valid_r[i] <= (addr_wr_r[i] | wr_addr_hit_s[i]) &
                            (size_wr_r[i] | wr_size_hit_s[i]);
        end
      end
      state_r   <= state_nxt_s;
      done_r    <= done_nxt_s;
      start_r   <= start_s;
      kreset_r  <= (state_nxt_s == S_RESET);
      running_r <= (state_nxt_s == S_RUN);
    end
  end

  // Read data mux from current (pre-write) register values.
  always_comb begin
    rd_desc_s = 64'h0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      rd_desc_s = rd_desc_s
                | ((byte_addr_s == desc_byte(i, 1'b0)) ? buf_addr_r[i] : 64'h0)
                | ((byte_addr_s == desc_byte(i, 1'b1)) ? {32'h0, buf_size_r[i]} : 64'h0);
    end
    case (byte_addr_s)
      ADDR_STATUS: rd_data_s = {60'h0, done_r, state_r};
      ADDR_DSM:    rd_data_s = dsm_base_r;
      ADDR_CTRL:   rd_data_s = {32'h0, ctrl_r};
      default:     rd_data_s = rd_desc_s;
    endcase
  end

  // Two-stage read response pipeline; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld1_r  <= 1'b0;
      rd_tid1_r  <= 9'h0;
      rd_data1_r <= 64'h0;
      rsp_r      <= '{hdr: '{tid: 9'h0}, mmioRdValid: 1'b0, data: 64'h0};
    end else begin
      rd_vld1_r         <= rd_hit_s;
      rd_tid1_r         <= cp2af_mmio_c0rx.hdr.tid;
      rd_data1_r        <= rd_data_s;
      rsp_r.mmioRdValid <= rd_vld1_r;
      rsp_r.hdr.tid     <= rd_tid1_r;
      rsp_r.data        <= rd_data1_r;
    end
  end

  assign af2cp_mmio_c2tx = rsp_r;
  assign dsm_base        = dsm_base_r;
  assign buf_valid       = buf_valid_r;
  assign kernel_reset    = kreset_r;
  assign kernel_start    = start_r;
  assign kernel_running  = running_r;

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_desc_out
    assign buf_addr[64*g +: 64] = buf_addr_r[g];
    assign buf_size[32*g +: 32] = buf_size_r[g];
  end

endmodule
